fetch_issue_unit: RTL

//  Producer end of the fetch->decode interface: owns the PC, issues instruction-memory reads,
//  and delivers {instruction, PC+2} to decode through a 2-entry skid FIFO with valid/ready.

---
 rtl/fetch_issue_unit_pkg.sv | 7 +
 rtl/fetch_skid_fifo.sv | 44 ++++
 rtl/fetch_issue_unit.sv | 87 ++++++++
 3 files changed

// File: rtl/fetch_issue_unit_pkg.sv
// fetch_issue_unit_pkg: shared constants and fetch FSM state encoding
package fetch_issue_unit_pkg;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OP_HALT   = 5'b00000;
    localparam int          PC_INC    = 2;
    typedef enum logic [1:0] {ST_FETCH, ST_FULL, ST_SQUASH, ST_HALT} fetch_state_e;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: small skid FIFO of {instr, pc_2} entries with clear and pop-before-push when full
module fetch_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   clear_i,
    input  logic [W-1:0]           data_i,
    output logic [W-1:0]           data_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (cnt_q != (AW+1)'(DEPTH) || do_pop);
    // storage and pointers; a pop frees its slot in the same cycle a push may refill it
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clear_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= data_i;
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/fetch_issue_unit.sv
// fetch_issue_unit: PC owner issuing imem reads and feeding decode through a skid FIFO
module fetch_issue_unit
    import fetch_issue_unit_pkg::*;
#(
    parameter int                DATA_W     = 16,
    parameter logic [DATA_W-1:0] PC_RESET   = '0,
    parameter int                FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    output logic              imem_req_o,
    output logic [DATA_W-1:0] imem_addr_o,
    input  logic [DATA_W-1:0] imem_data_i,
    input  logic              imem_done_i,
    input  logic              redirect_en_i,
    input  logic [DATA_W-1:0] redirect_pc_i,
    output logic              dec_valid_o,
    input  logic              dec_ready_i,
    output logic [DATA_W-1:0] dec_instr_o,
    output logic [DATA_W-1:0] dec_pc_2_o,
    output logic              halted_o
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    fetch_state_e        state_q, state_d;
    logic [DATA_W-1:0]   pc_q, pc_d, sq_addr_q, sq_addr_d, pc_next;
    logic                started_q;
    logic                push, pop, empty, fill, halt_op, ret;
    logic [CW-1:0]       count;
    logic [2*DATA_W-1:0] head;

    assign imem_req_o  = started_q && (state_q == ST_FETCH || state_q == ST_SQUASH);
    assign imem_addr_o = state_q == ST_SQUASH ? sq_addr_q : pc_q;
    assign halted_o    = state_q == ST_HALT;
    assign dec_valid_o = !empty;
    assign dec_instr_o = empty ? DATA_W'(NOP_INSTR) : head[2*DATA_W-1:DATA_W];
    assign dec_pc_2_o  = empty ? '0 : head[DATA_W-1:0];
    assign pc_next     = pc_q + DATA_W'(PC_INC);
    assign ret         = imem_req_o && imem_done_i;
    assign push        = ret && state_q == ST_FETCH && !redirect_en_i;
    assign pop         = dec_valid_o && dec_ready_i;
    assign fill        = push && !pop && count == CW'(FIFO_DEPTH - 1);
    assign halt_op     = imem_data_i[DATA_W-1 -: 5] == OP_HALT;

    fetch_skid_fifo #(.DEPTH(FIFO_DEPTH), .W(2*DATA_W)) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect_en_i),
        .data_i  ({imem_data_i, pc_next}),
        .data_o  (head),
        .empty_o (empty),
        .count_o (count)
    );

    // next state, PC and squash address; redirect overrides everything else
    always_comb begin
        state_d   = state_q;
        pc_d      = push ? pc_next : pc_q;
        sq_addr_d = (redirect_en_i && state_q == ST_FETCH) ? pc_q : sq_addr_q;
        case (state_q)
            ST_FETCH:  if (ret) state_d = halt_op ? ST_HALT : fill ? ST_FULL : ST_FETCH;
            ST_FULL:   if (pop) state_d = ST_FETCH;
            ST_SQUASH: if (ret) state_d = ST_FETCH;
            default:   state_d = ST_HALT;
        endcase
        if (redirect_en_i) begin
            pc_d    = redirect_pc_i;
            state_d = (imem_req_o && !imem_done_i) ? ST_SQUASH : ST_FETCH;
        end
    end

    // state registers; started_q holds off the first request until the cycle after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_FETCH;
            pc_q      <= PC_RESET;
            sq_addr_q <= PC_RESET;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            sq_addr_q <= sq_addr_d;
            started_q <= 1'b1;
        end
    end
endmodule
